// File: rtl/dds_rafa_sincos.sv
// Quadrature sine/cosine DDS: 32-bit phase accumulator, quarter-wave lookup,
// registered outputs and a one-cycle pulse on every accumulator wrap.
module dds_rafa_sincos #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 12,
    parameter int OUT_W   = 14,
    parameter int AMPL    = 8191
) (
    input  logic                     clk125,
    input  logic                     areset_n,
    input  logic                     clken,
    input  logic [PHASE_W-1:0]       phi_inc_i,
    output logic signed [OUT_W-1:0]  fsin_o,
    output logic signed [OUT_W-1:0]  fcos_o,
    output logic                     pulso,
    output logic                     out_valid
);

    localparam int QN = 1 << (LUT_AW - 2);
    localparam int MW = OUT_W - 1;
    localparam int FX = 56;
    localparam logic [127:0] PI_FX = 128'h3243F6A8885A308;

    // round(AMPL*sin(2*pi*p/2^LUT_AW)) for the first quadrant, evaluated at
    // elaboration with a 56-bit fixed-point Taylor series so rounding is exact.
    function automatic logic [MW-1:0] quarter_sin(input int p);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        x    = (PI_FX * 128'(p)) >> (LUT_AW - 1);
        x2   = (x * x) >> FX;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> FX) / 128'(2 * n * (2 * n + 1));
            if ((n % 2) == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        sum = (sum * 128'(AMPL) + (128'd1 << (FX - 1))) >> FX;
        return MW'(sum);
    endfunction

    logic [PHASE_W-1:0]       r_acc;
    logic                     r_carry;
    logic signed [OUT_W-1:0]  r_fsin;
    logic signed [OUT_W-1:0]  r_fcos;
    logic                     r_pulso;
    logic                     r_v1;
    logic                     r_valid;

    logic [PHASE_W:0]         w_sum;
    logic [LUT_AW-1:0]        w_phase;
    logic [MW-1:0]            w_qrom [0:QN];
    logic signed [OUT_W-1:0]  w_lut  [0:1];

    assign w_sum   = {1'b0, r_acc} + {1'b0, phi_inc_i};
    assign w_phase = r_acc[PHASE_W-1 -: LUT_AW];

    genvar gi;
    generate
        for (gi = 0; gi <= QN; gi++) begin : g_rom
            assign w_qrom[gi] = quarter_sin(gi);
        end

        // Channel 0 is sine, channel 1 is the same table a quarter turn ahead.
        for (gi = 0; gi < 2; gi++) begin : g_lut
            logic [LUT_AW-1:0] w_idx;
            logic [LUT_AW-2:0] w_addr;
            logic [MW-1:0]     w_mag;
            assign w_idx  = w_phase + LUT_AW'(gi * QN);
            assign w_addr = w_idx[LUT_AW-2] ? (LUT_AW-1)'(QN) - {1'b0, w_idx[LUT_AW-3:0]}
                                            : {1'b0, w_idx[LUT_AW-3:0]};
            assign w_mag  = w_qrom[w_addr];
            assign w_lut[gi] = w_idx[LUT_AW-1] ? -$signed({1'b0, w_mag})
                                               :  $signed({1'b0, w_mag});
        end
    endgenerate

    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_fsin  <= '0;
            r_fcos  <= '0;
            r_pulso <= 1'b0;
            r_v1    <= 1'b0;
            r_valid <= 1'b0;
        end else if (clken) begin
            r_acc   <= w_sum[PHASE_W-1:0];
            r_carry <= w_sum[PHASE_W];
            r_fsin  <= w_lut[0];
            r_fcos  <= w_lut[1];
            r_pulso <= r_carry;
            r_v1    <= 1'b1;
            r_valid <= r_v1;
        end else begin
            // A stalled pipeline must not present the same wrap twice.
            r_pulso <= 1'b0;
        end
    end

    assign fsin_o    = r_fsin;
    assign fcos_o    = r_fcos;
    assign pulso     = r_pulso;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_dds_rafa_sincos.sv
// Directed bench for dds_rafa_sincos: start-up sequence, slow sweep, tuning
// switch, clock-enable stall, asynchronous reset and negative frequency.
module tb_dds_rafa_sincos;

    logic               clk125 = 1'b0;
    logic               areset_n = 1'b1;
    logic               clken = 1'b1;
    logic [31:0]        phi_inc_i = 32'd0;
    logic signed [13:0] fsin_o;
    logic signed [13:0] fcos_o;
    logic               pulso;
    logic               out_valid;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int sin_hist [0:8200];
    int cos_hist [0:8200];

    dds_rafa_sincos dut (
        .clk125    (clk125),
        .areset_n  (areset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o),
        .pulso     (pulso),
        .out_valid (out_valid)
    );

    always #4 clk125 = ~clk125;

    // Reference lookup: round(8191*sin(2*pi*p/4096)), half away from zero.
    function automatic int s_ref(input int p);
        int  pp;
        real v;
        pp = p & 4095;
        v  = 8191.0 * $sin(2.0 * 3.14159265358979323846 * pp / 4096.0);
        if (v >= 0.0)
            return int'($floor(v + 0.5));
        else
            return -int'($floor(-v + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    // Reset released between edges; the next rising edge is "edge 1".
    task automatic do_reset(input logic [31:0] phi);
        @(posedge clk125);
        #2;
        areset_n  = 1'b0;
        phi_inc_i = phi;
        clken     = 1'b1;
        repeat (2) @(posedge clk125);
        #2;
        areset_n = 1'b1;
    endtask

    // Quarter-rate sequence expected after release with phi_inc_i=0x40000000.
    task automatic run_startup_seq(input string tag);
        int es, ec;
        logic ep, ev;
        for (int i = 0; i < 12; i++) begin
            tick();
            es = (i % 2 == 0) ? 0 : ((i % 4 == 1) ? 8191 : -8191);
            ec = (i % 2 == 1) ? 0 : ((i % 4 == 0) ? 8191 : -8191);
            ep = (i >= 4) && (i % 4 == 0);
            ev = (i >= 1);
            assert_cnt += 4;
            if (fsin_o !== 14'(es)) begin
                fail_cnt++;
                $display("FAIL %s_fsin edge %0d: got %0d expected %0d", tag, i + 1, fsin_o, es);
            end
            if (fcos_o !== 14'(ec)) begin
                fail_cnt++;
                $display("FAIL %s_fcos edge %0d: got %0d expected %0d", tag, i + 1, fcos_o, ec);
            end
            if (pulso !== ep) begin
                fail_cnt++;
                $display("FAIL %s_pulso edge %0d: got %b expected %b", tag, i + 1, pulso, ep);
            end
            if (out_valid !== ev) begin
                fail_cnt++;
                $display("FAIL %s_valid edge %0d: got %b expected %b", tag, i + 1, out_valid, ev);
            end
        end
        $display("%s: 12-edge start-up sequence checked", tag);
    endtask

    task automatic test_reset();
        phi_inc_i = 32'h4000_0000;
        #2;
        areset_n = 1'b0;
        #1;
        assert_cnt += 4;
        if (fsin_o !== 14'sd0) begin
            fail_cnt++;
            $display("FAIL reset_fsin: got %0d expected 0", fsin_o);
        end
        if (fcos_o !== 14'sd0) begin
            fail_cnt++;
            $display("FAIL reset_fcos: got %0d expected 0", fcos_o);
        end
        if (pulso !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_pulso: got %b expected 0", pulso);
        end
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        $display("test_reset: outputs checked while in reset");
    endtask

    task automatic test_startup();
        do_reset(32'h4000_0000);
        run_startup_seq("startup");
    endtask

    // 2^20 step: index k-1 at edge k, wraps after 4096 edges.
    task automatic test_slow_sweep();
        int es, ec;
        logic ep;
        do_reset(32'h0010_0000);
        for (int k = 1; k <= 8200; k++) begin
            tick();
            sin_hist[k] = int'(fsin_o);
            cos_hist[k] = int'(fcos_o);
            es = s_ref(k - 1);
            ec = s_ref(k - 1 + 1024);
            ep = (k == 4097) || (k == 8193);
            assert_cnt += 3;
            if (fsin_o !== 14'(es)) begin
                fail_cnt++;
                $display("FAIL sweep_fsin edge %0d: got %0d expected %0d", k, fsin_o, es);
            end
            if (fcos_o !== 14'(ec)) begin
                fail_cnt++;
                $display("FAIL sweep_fcos edge %0d: got %0d expected %0d", k, fcos_o, ec);
            end
            if (pulso !== ep) begin
                fail_cnt++;
                $display("FAIL sweep_pulso edge %0d: got %b expected %b", k, pulso, ep);
            end
            if (k == 2 || k == 3 || k == 1025) begin
                es = (k == 2) ? 13 : ((k == 3) ? 25 : 8191);
                assert_cnt++;
                if (fsin_o !== 14'(es)) begin
                    fail_cnt++;
                    $display("FAIL sweep_key edge %0d: got %0d expected %0d", k, fsin_o, es);
                end
            end
        end
        for (int k = 1; k + 1024 <= 8200; k++) begin
            assert_cnt++;
            if (cos_hist[k] !== sin_hist[k + 1024]) begin
                fail_cnt++;
                $display("FAIL sweep_quadrature edge %0d: fcos %0d fsin(+1024) %0d", k, cos_hist[k], sin_hist[k + 1024]);
            end
        end
        $display("test_slow_sweep: 8200 edges checked");
    endtask

    // Output index 100 appears at edge 101; doubling the step there gives
    // indices 101, 103, 105, ... with wraps seen at edges 2100 and 4148.
    task automatic test_freq_switch();
        int idx;
        int es;
        logic ep;
        do_reset(32'h0010_0000);
        idx = 0;
        for (int k = 1; k <= 4160; k++) begin
            tick();
            es = s_ref(idx);
            ep = (k == 2100) || (k == 4148);
            assert_cnt += 2;
            if (fsin_o !== 14'(es)) begin
                fail_cnt++;
                $display("FAIL switch_fsin edge %0d: got %0d expected %0d (index %0d)", k, fsin_o, es, idx & 4095);
            end
            if (pulso !== ep) begin
                fail_cnt++;
                $display("FAIL switch_pulso edge %0d: got %b expected %b", k, pulso, ep);
            end
            if (k == 101) phi_inc_i = 32'h0020_0000;
            idx += (k <= 101) ? 1 : 2;
        end
        $display("test_freq_switch: 4160 edges checked");
    endtask

    // Stall right after the edge that shows pulso=1.
    task automatic test_clken();
        int es [4] = '{8191, 0, -8191, 0};
        int ec [4] = '{0, -8191, 0, 8191};
        do_reset(32'h4000_0000);
        repeat (5) tick();
        assert_cnt++;
        if (pulso !== 1'b1) begin
            fail_cnt++;
            $display("FAIL clken_pre_pulso: got %b expected 1", pulso);
        end
        clken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            assert_cnt += 4;
            if (fsin_o !== 14'sd0) begin
                fail_cnt++;
                $display("FAIL clken_hold_fsin cycle %0d: got %0d expected 0", i, fsin_o);
            end
            if (fcos_o !== 14'sd8191) begin
                fail_cnt++;
                $display("FAIL clken_hold_fcos cycle %0d: got %0d expected 8191", i, fcos_o);
            end
            if (pulso !== 1'b0) begin
                fail_cnt++;
                $display("FAIL clken_hold_pulso cycle %0d: got %b expected 0", i, pulso);
            end
            if (out_valid !== 1'b1) begin
                fail_cnt++;
                $display("FAIL clken_hold_valid cycle %0d: got %b expected 1", i, out_valid);
            end
        end
        clken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            assert_cnt += 3;
            if (fsin_o !== 14'(es[i])) begin
                fail_cnt++;
                $display("FAIL clken_resume_fsin edge %0d: got %0d expected %0d", i, fsin_o, es[i]);
            end
            if (fcos_o !== 14'(ec[i])) begin
                fail_cnt++;
                $display("FAIL clken_resume_fcos edge %0d: got %0d expected %0d", i, fcos_o, ec[i]);
            end
            if (pulso !== (i == 3)) begin
                fail_cnt++;
                $display("FAIL clken_resume_pulso edge %0d: got %b expected %b", i, pulso, (i == 3));
            end
        end
        $display("test_clken: stall and resume checked");
    endtask

    task automatic test_async_reset();
        do_reset(32'h4000_0000);
        repeat (5) tick();
        #2;
        areset_n = 1'b0;
        #1;
        assert_cnt += 4;
        if (fsin_o !== 14'sd0) begin
            fail_cnt++;
            $display("FAIL async_fsin: got %0d expected 0", fsin_o);
        end
        if (fcos_o !== 14'sd0) begin
            fail_cnt++;
            $display("FAIL async_fcos: got %0d expected 0", fcos_o);
        end
        if (pulso !== 1'b0) begin
            fail_cnt++;
            $display("FAIL async_pulso: got %b expected 0", pulso);
        end
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL async_valid: got %b expected 0", out_valid);
        end
        repeat (2) @(posedge clk125);
        #2;
        areset_n = 1'b1;
        run_startup_seq("async");
    endtask

    // -2^20 step: index decrements; carry on every add except from phase 0.
    task automatic test_negative();
        int es, ec;
        logic ep;
        do_reset(32'hFFF0_0000);
        for (int k = 1; k <= 20; k++) begin
            tick();
            es = s_ref(-(k - 1));
            ec = s_ref(-(k - 1) + 1024);
            ep = (k >= 3);
            assert_cnt += 3;
            if (fsin_o !== 14'(es)) begin
                fail_cnt++;
                $display("FAIL neg_fsin edge %0d: got %0d expected %0d", k, fsin_o, es);
            end
            if (fcos_o !== 14'(ec)) begin
                fail_cnt++;
                $display("FAIL neg_fcos edge %0d: got %0d expected %0d", k, fcos_o, ec);
            end
            if (pulso !== ep) begin
                fail_cnt++;
                $display("FAIL neg_pulso edge %0d: got %b expected %b", k, pulso, ep);
            end
            if (k == 2 || k == 3) begin
                es = (k == 2) ? -13 : -25;
                assert_cnt++;
                if (fsin_o !== 14'(es)) begin
                    fail_cnt++;
                    $display("FAIL neg_key edge %0d: got %0d expected %0d", k, fsin_o, es);
                end
            end
        end
        $display("test_negative: 20 edges checked");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_slow_sweep();
        test_freq_switch();
        test_clken();
        test_async_reset();
        test_negative();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
